contador_con_echo: RTL and testbench
====================================

# contador_con_echo

Measures the width of the echo pulse from an ultrasonic range sensor (HC-SR04 style) in system-clock cycles. The block synchronizes the asynchronous `echo` input and counts clock cycles while it is high. On the falling edge it publishes the count on `contador2`, which holds until the next pulse ends. It sits between the sensor pin and the distance-conversion logic. At the 50 MHz system clock, one count is 20 ns.

## Interface
- `WIDTH`, default 20. Counter and output width.
- `SYNC_STAGES`, default 2, minimum 2. Number of flip-flops in the `echo` synchronizer.
- `clk`  in  1  System clock; rising edge active; 50 MHz nominal.
- `rst_n`  in  1  Reset; synchronous, active-low.
- `echo`  in  1  Asynchronous sensor echo; high while the pulse lasts.
- `contador2`  out  WIDTH  Width of the last completed pulse, in clock cycles.
- `listo`  out  1  One-cycle strobe; high in the cycle `contador2` is updated.
- `desborde`  out  1  High when the last completed pulse saturated the counter; updated together with `contador2`.

## Operation
- `echo` passes through a `SYNC_STAGES` flip-flop chain to produce `s`. A register `s_prev` holds the previous value of `s`.
- Rising edge: `s & ~s_prev` → internal counter `cnt` <= 1.
- While `s` stays high: `cnt` <= `cnt + 1`, saturating at `2^WIDTH - 1` (never wraps). The saturated state is remembered in a `sat` flag.
- Falling edge: `~s & s_prev` →
  - `contador2` <= `cnt`
  - `desborde` <= `sat`
  - `listo` <= 1 for exactly one cycle
  - `cnt` and `sat` are then cleared.
- While `s` is low and no edge occurs, `cnt` holds 0. `contador2` and `desborde` hold their last values.
- Result: `contador2` equals the number of rising edges of `clk` at which `echo` was sampled high during the pulse.
- Reset (`rst_n` = 0 at a rising edge) clears all of the following to 0: the synchronizer, `s_prev`, `cnt`, `sat`, `contador2`, `listo`, `desborde`. Reset has priority over all other logic.
- Reset mid-pulse: the partial count is discarded and no result is published. If `echo` is still high after reset is released, that is treated as a new rising edge, and the reported width counts only from release.
- A pulse one cycle wide yields `contador2` = 1. A glitch shorter than one clock period that is never sampled high produces no update.

## Timing
- Let k0 be the first rising edge at which `echo` is sampled low after a pulse. `contador2`, `desborde` and `listo` update at edge k0 + `SYNC_STAGES`.
- `listo` falls at the following edge.
- The measurement delay is identical on both edges, so the latency does not bias the count.
- Back-to-back pulses need at least one low sample between them; each pulse produces its own update.
- Maximum measurable width: `2^20 - 1` cycles ≈ 20.97 ms at 50 MHz, which covers the sensor's 38 ms no-object pulse only by saturation. That case is flagged with `desborde`.

## Structure
- Shared package `ultrasonido_pkg` contains:
  - `CNT_WIDTH` = 20
  - `CLK_PERIOD_NS` = 20
  - `CNT_MAX` = `2^CNT_WIDTH - 1`
- One sub-module, `sincronizador_flanco`: the `SYNC_STAGES` synchronizer plus `s_prev`. Outputs `s`, `sube` (rising edge) and `baja` (falling edge).
- The top level holds the saturating counter and the output registers.

## Test plan
- Reset: hold `rst_n` = 0 for 5 cycles with `echo` = 1 → `contador2` = 0, `listo` = 0, `desborde` = 0 throughout.
- Nominal pulse, 20 ns clock: `echo` 0→1 at t = 100 ns, held for 600000 ns, then 0 → `contador2` = 30000, one `listo` pulse `SYNC_STAGES` edges after the first low sample, `desborde` = 0; the value holds afterwards.
- Two pulses of 5 cycles and then 12 cycles, separated by 3 low cycles → `contador2` = 5 first, then 12; exactly two `listo` strobes.
- Minimum pulse: `echo` high for exactly one sampled edge → `contador2` = 1.
- Saturation with `WIDTH` = 8: pulse of 300 cycles → `contador2` = 255, `desborde` = 1. Next pulse of 10 cycles → `contador2` = 10, `desborde` = 0.
- Reset mid-pulse: `rst_n` low for 2 cycles during a pulse, `echo` still high for 40 cycles after release → `contador2` = 40, no `listo` during the reset.

Source files
------------

// File: rtl/ultrasonido_pkg.sv
// Shared constants and types for the ultrasonic ranging datapath.
package ultrasonido_pkg;

  localparam int unsigned CNT_WIDTH     = 20;
  localparam int unsigned CLK_PERIOD_NS = 20;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Pulse measurement state: waiting for a pulse, or counting one.
  typedef enum logic {
    ST_REPOSO   = 1'b0,
    ST_MIDIENDO = 1'b1
  } estado_e;

endpackage : ultrasonido_pkg

// File: rtl/contador_con_echo_sincronizador_flanco.sv
// Echo synchronizer chain plus previous-sample register and edge detection.
module sincronizador_flanco #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic echo_i,
  output logic s_o,
  output logic sube_o,
  output logic baja_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;

  // Shift the asynchronous echo through the chain and keep the last sample.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], echo_i};
      s_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign sube_o = s_o & ~s_prev_q;
  assign baja_o = ~s_o & s_prev_q;

endmodule : sincronizador_flanco

// File: rtl/contador_con_echo.sv
// Echo pulse-width meter: saturating cycle counter with registered result.
module contador_con_echo
  import ultrasonido_pkg::*;
#(
  parameter int unsigned WIDTH       = CNT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             echo,
  output logic [WIDTH-1:0] contador2,
  output logic             listo,
  output logic             desborde
);

  localparam logic [WIDTH-1:0] MAX_W = '1;
  localparam logic [WIDTH-1:0] UNO_W = WIDTH'(1);

  logic s, sube, baja;

  estado_e          estado_q, estado_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] contador2_q, contador2_d;
  logic             desborde_q, desborde_d;
  logic             listo_q, listo_d;

  sincronizador_flanco #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .echo_i (echo),
    .s_o    (s),
    .sube_o (sube),
    .baja_o (baja)
  );

  // State, counter and published-result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q    <= ST_REPOSO;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      contador2_q <= '0;
      desborde_q  <= 1'b0;
      listo_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      contador2_q <= contador2_d;
      desborde_q  <= desborde_d;
      listo_q     <= listo_d;
    end
  end

  // Next-state: start at 1 on a rising edge, saturate while high, publish on fall.
  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    contador2_d = contador2_q;
    desborde_d  = desborde_q;
    listo_d     = 1'b0;
    unique case (estado_q)
      ST_REPOSO: begin
        cnt_d = '0;
        sat_d = 1'b0;
        if (sube) begin
          cnt_d    = UNO_W;
          estado_d = ST_MIDIENDO;
        end
      end
      ST_MIDIENDO: begin
        if (baja) begin
          contador2_d = cnt_q;
          desborde_d  = sat_q;
          listo_d     = 1'b1;
          cnt_d       = '0;
          sat_d       = 1'b0;
          estado_d    = ST_REPOSO;
        end else if (s) begin
          if (cnt_q == MAX_W) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + UNO_W;
          end
        end
      end
      default: begin
        estado_d = ST_REPOSO;
      end
    endcase
  end

  assign contador2 = contador2_q;
  assign desborde  = desborde_q;
  assign listo     = listo_q;

endmodule : contador_con_echo

// File: tb/tb_contador_con_echo.sv
// Bench for contador_con_echo: a 20-bit/2-stage and an 8-bit/3-stage instance
// share clock, reset and echo; expected results queue up per instance.
module tb_contador_con_echo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        echo;
  logic [19:0] c2_a;
  logic        listo_a, desb_a;
  logic [7:0]  c2_b;
  logic        listo_b, desb_b;

  always #10 clk = ~clk;

  contador_con_echo #(.WIDTH(20), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .echo(echo),
    .contador2(c2_a), .listo(listo_a), .desborde(desb_a)
  );

  contador_con_echo #(.WIDTH(8), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .echo(echo),
    .contador2(c2_b), .listo(listo_b), .desborde(desb_b)
  );

  typedef struct {
    logic [19:0] val;
    logic        ovf;
    int unsigned edge_n;
  } exp_t;

  typedef struct {
    int unsigned len;
    int unsigned gap;
    logic [19:0] exp20;
    logic        ovf20;
    logic [7:0]  exp8;
    logic        ovf8;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  logic        rst_at_edge = 1'b0;

  logic [19:0] hold_a = '0;
  logic        hovf_a = 1'b0;
  logic [7:0]  hold_b = '0;
  logic        hovf_b = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: listo strobe with nothing expected (t=%0t)", name, $time);
  endtask

  // Monitor for the 20-bit instance, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_at_edge) begin
      hold_a = '0;
      hovf_a = 1'b0;
    end
    if (listo_a === 1'b1) begin
      if (qa.size() == 0) begin
        unexpected("listo_a");
      end else begin
        e = qa.pop_front();
        check("c2_a", 32'(c2_a), 32'(e.val));
        check("desb_a", 32'(desb_a), 32'(e.ovf));
        check("lat_a", cyc, e.edge_n);
        hold_a = e.val;
        hovf_a = e.ovf;
      end
    end else begin
      check("listo_a_low", 32'(listo_a), 32'd0);
      check("hold_c2_a", 32'(c2_a), 32'(hold_a));
      check("hold_desb_a", 32'(desb_a), 32'(hovf_a));
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_at_edge) begin
      hold_b = '0;
      hovf_b = 1'b0;
    end
    if (listo_b === 1'b1) begin
      if (qb.size() == 0) begin
        unexpected("listo_b");
      end else begin
        e = qb.pop_front();
        check("c2_b", 32'(c2_b), 32'(e.val));
        check("desb_b", 32'(desb_b), 32'(e.ovf));
        check("lat_b", cyc, e.edge_n);
        hold_b = e.val[7:0];
        hovf_b = e.ovf;
      end
    end else begin
      check("listo_b_low", 32'(listo_b), 32'd0);
      check("hold_c2_b", 32'(c2_b), 32'(hold_b));
      check("hold_desb_b", 32'(desb_b), 32'(hovf_b));
    end
  end

  // Called right after echo drops between edges; next edge is the first low sample.
  task automatic push_expected(input logic [19:0] e20, input logic o20,
                               input logic [7:0] e8, input logic o8);
    int unsigned k0;
    exp_t ea;
    exp_t eb;
    k0 = cyc + 1;
    ea.val = e20;
    ea.ovf = o20;
    ea.edge_n = k0 + 2;
    eb.val = 20'(e8);
    eb.ovf = o8;
    eb.edge_n = k0 + 3;
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{len: 1,   gap: 4, exp20: 20'd1,   ovf20: 1'b0, exp8: 8'd1,   ovf8: 1'b0},
      '{len: 5,   gap: 3, exp20: 20'd5,   ovf20: 1'b0, exp8: 8'd5,   ovf8: 1'b0},
      '{len: 12,  gap: 4, exp20: 20'd12,  ovf20: 1'b0, exp8: 8'd12,  ovf8: 1'b0},
      '{len: 2,   gap: 1, exp20: 20'd2,   ovf20: 1'b0, exp8: 8'd2,   ovf8: 1'b0},
      '{len: 3,   gap: 4, exp20: 20'd3,   ovf20: 1'b0, exp8: 8'd3,   ovf8: 1'b0},
      '{len: 254, gap: 4, exp20: 20'd254, ovf20: 1'b0, exp8: 8'd254, ovf8: 1'b0},
      '{len: 256, gap: 4, exp20: 20'd256, ovf20: 1'b0, exp8: 8'd255, ovf8: 1'b1},
      '{len: 300, gap: 4, exp20: 20'd300, ovf20: 1'b0, exp8: 8'd255, ovf8: 1'b1},
      '{len: 10,  gap: 4, exp20: 20'd10,  ovf20: 1'b0, exp8: 8'd10,  ovf8: 1'b0}
    };

    // Reset held with echo high: outputs stay cleared.
    rst_n = 1'b0;
    echo  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_c2_a", 32'(c2_a), 32'd0);
      check("rst_listo_a", 32'(listo_a), 32'd0);
      check("rst_desb_a", 32'(desb_a), 32'd0);
      check("rst_c2_b", 32'(c2_b), 32'd0);
      check("rst_listo_b", 32'(listo_b), 32'd0);
    end
    echo  = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal 600 us pulse, edges placed off the clock grid.
    #3 echo = 1'b1;
    #600000 echo = 1'b0;
    push_expected(20'd30000, 1'b0, 8'd255, 1'b1);
    repeat (10) @(negedge clk);

    // Table of pulse lengths and gaps.
    for (int unsigned i = 0; i < vecs.size(); i++) begin
      echo = 1'b1;
      repeat (vecs[i].len) @(negedge clk);
      echo = 1'b0;
      push_expected(vecs[i].exp20, vecs[i].ovf20, vecs[i].exp8, vecs[i].ovf8);
      repeat (vecs[i].gap) @(negedge clk);
    end
    repeat (10) @(negedge clk);

    // Glitch between edges: never sampled, no update.
    #2 echo = 1'b1;
    #3 echo = 1'b0;
    repeat (10) @(negedge clk);

    // Reset mid-pulse: count restarts at release.
    echo = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    echo = 1'b0;
    push_expected(20'd40, 1'b0, 8'd40, 1'b0);

    // Drain, bounded.
    for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    while (qa.size() != 0) begin
      exp_t e;
      e = qa.pop_front();
      tests++;
      fails++;
      $display("FAIL drain_a: result %0d never published, expected at edge %0d", e.val, e.edge_n);
    end
    while (qb.size() != 0) begin
      exp_t e;
      e = qb.pop_front();
      tests++;
      fails++;
      $display("FAIL drain_b: result %0d never published, expected at edge %0d", e.val, e.edge_n);
    end
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_contador_con_echo
